fetch_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC register, the next-PC select and the IF/ID pipeline register.
- Consumes the hazard unit's stall/flush outputs (PC hold, IF/ID hold, IF/ID flush) plus the branch and jump redirects.
- Produces the fetched instruction and PC+4 for decode.
- Keeps saturating stall/squash counters and a sticky hold-mismatch flag for debug.

---
 rtl/pipe_pkg.sv | 7 +
 rtl/fetch_stage_if.sv | 11 +
 rtl/fetch_stage_sat_counter.sv | 17 +
 rtl/fetch_stage.sv | 111 +++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Constants shared by the fetch stage: NOP encoding, decode jump codes, default reset PC.
package pipe_pkg;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [2:0]  JMP_J            = 3'd1;
  localparam logic [2:0]  JMP_JAL          = 3'd2;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and a zero-wait instruction memory.
interface fetch_stage_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/fetch_stage_sat_counter.sv
// Counter that increments on inc and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select, IF/ID register and debug counters.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_hold,
  input  logic               ifid_hold,
  input  logic               flush_ifid,
  input  logic [2:0]         jump_sel,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  fetch_stage_if.master      imem,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc4,
  output logic               if_id_valid,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   squash_cnt,
  output logic               hold_err
);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_plus4;
  logic              jump_act;
  logic              redirect;
  logic              squash;
  logic              stall_inc;
  logic              hold_err_reg;

  always_comb begin
    jump_act  = (jump_sel == JMP_J) || (jump_sel == JMP_JAL);
    redirect  = branch_taken || jump_act;
    squash    = flush_ifid || redirect;
    stall_inc = ifid_hold && !squash;
    pc_plus4  = pc_reg + ADDR_W'(4);

    // Redirects take precedence over pc_hold; branch resolves later so it beats jump.
    pc_next = pc_plus4;
    if (branch_taken) begin
      pc_next = branch_target & WORD_MASK;
    end else if (jump_act) begin
      pc_next = jump_target & WORD_MASK;
    end else if (pc_hold) begin
      pc_next = pc_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign imem.imem_addr = pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_instr <= INSTR_W'(INSTR_NOP);
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (squash) begin
      if_id_instr <= INSTR_W'(INSTR_NOP);
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (!ifid_hold) begin
      if_id_instr <= imem.imem_data;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end

  // Disagreeing holds only matter when no redirect is rewriting both registers anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_err_reg <= 1'b0;
    end else if ((pc_hold != ifid_hold) && !redirect) begin
      hold_err_reg <= 1'b1;
    end
  end

  assign hold_err = hold_err_reg;

  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc = {squash, stall_inc};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc[gi]),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  assign stall_cnt  = cnt_val[0];
  assign squash_cnt = cnt_val[1];
endmodule
